// File: rtl/fpu_divsqrt_iter.sv
// fpu_divsqrt_iter
//   Iterative radix-2 mantissa divider / square-root unit. This is the
//   responder side of the FPU multi-cycle start/done handshake. It produces
//   one quotient/root bit per cycle, MSB first, by restoring subtraction.
//   Special operands, and divides by zero, are acknowledged in the same cycle
//   as start.
//
// Ports
//   clk      in   clock
//   reset    in   asynchronous active-low reset
//   start    in   operation request, held high by the controller until done
//   is_sqrt  in   1 = sqrt(mant_a), 0 = mant_a / mant_b
//   special  in   operand already classified as zero/inf/NaN upstream
//   mant_a   in   dividend or radicand (MANT_W)
//   mant_b   in   divisor, normalized (MANT_W), ignored for sqrt
//   done     out  result valid / acknowledge
//   busy     out  iteration in progress
//   result   out  quotient or root (Q_W)
//   sticky   out  final partial remainder nonzero
//
// Optional feature
//   FPU_DIVSQRT_EARLY_EXIT_EN : finish as soon as the partial remainder (and,
//   for sqrt, the unconsumed radicand) is zero. The remaining result bits are
//   zero. Without it, latency is always Q_W+1 cycles.
//
// State table
//   S_IDLE | waiting for start; immediate acknowledge of special operands
//   S_BUSY | one result bit per cycle, counter counts Q_W down to 1
//   S_DONE | done high, result/sticky stable until start drops
module fpu_divsqrt_iter #(
  parameter int MANT_W = 24,
  parameter int Q_W    = MANT_W + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_sqrt,
  input  logic              special,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic              done,
  output logic              busy,
  output logic [Q_W-1:0]    result,
  output logic              sticky
);

  localparam int R_W   = Q_W + 2;
  localparam int RAD_W = 2 * Q_W;
  localparam int CNT_W = $clog2(Q_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [R_W-1:0]     rem_q;
  logic [Q_W-1:0]     q_q;
  logic [RAD_W-1:0]   rad_q;
  logic [MANT_W-1:0]  div_q;
  logic               sqrt_q;
  logic [Q_W-1:0]     result_q;
  logic               sticky_q;

  logic               div0;
  logic               imm_ack;
  logic [R_W-1:0]     rem_sh;
  logic [R_W-1:0]     sub_y;
  logic [R_W:0]       diff;
  logic               bit_ok;
  logic [R_W-1:0]     rem_keep;
  logic [R_W-1:0]     rem_nxt;
  logic [RAD_W-1:0]   rad_nxt;
  logic [Q_W-1:0]     q_nxt;
  logic               finish;
  logic [Q_W-1:0]     res_fin;

  assign div0    = !is_sqrt && (mant_b == '0);
  assign imm_ack = (state_q == S_IDLE) && start && (special || div0);

  // Shared restoring step. Divide compares the remainder against the
  // divisor and shifts afterwards; sqrt first brings down two radicand bits
  // and compares against 4*root+1.
  always_comb begin
    rem_sh = rem_q;
    sub_y  = {{(R_W-MANT_W){1'b0}}, div_q};
    if (sqrt_q) begin
      rem_sh = {rem_q[R_W-3:0], rad_q[RAD_W-1 -: 2]};
      sub_y  = {q_q, 2'b01};
    end
    diff     = {1'b0, rem_sh} - {1'b0, sub_y};
    bit_ok   = !diff[R_W];
    rem_keep = bit_ok ? diff[R_W-1:0] : rem_sh;
    rem_nxt  = sqrt_q ? rem_keep : {rem_keep[R_W-2:0], 1'b0};
    rad_nxt  = {rad_q[RAD_W-3:0], 2'b00};
    q_nxt    = {q_q[Q_W-2:0], bit_ok};
  end

`ifdef FPU_DIVSQRT_EARLY_EXIT_EN
  // Once nothing is left to subtract, every later bit is zero; align the
  // bits produced so far to their final positions.
  always_comb begin
    finish  = (cnt_q == CNT_W'(1)) ||
              ((rem_nxt == '0) && (!sqrt_q || (rad_nxt == '0)));
    res_fin = q_nxt << (cnt_q - 1'b1);
  end
`else
  always_comb begin
    finish  = (cnt_q == CNT_W'(1));
    res_fin = q_nxt;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !imm_ack) state_d = S_BUSY;
      S_BUSY: begin
        if (!start)      state_d = S_IDLE;
        else if (finish) state_d = S_DONE;
      end
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      rad_q    <= '0;
      div_q    <= '0;
      sqrt_q   <= 1'b0;
      result_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start && !imm_ack) begin
        cnt_q  <= CNT_W'(Q_W);
        q_q    <= '0;
        div_q  <= mant_b;
        sqrt_q <= is_sqrt;
        if (is_sqrt) begin
          rem_q <= '0;
          rad_q <= {mant_a, {(RAD_W-MANT_W){1'b0}}};
        end else begin
          rem_q <= {{(R_W-MANT_W){1'b0}}, mant_a};
          rad_q <= '0;
        end
      end else if (state_q == S_BUSY && start) begin
        cnt_q <= cnt_q - 1'b1;
        rem_q <= rem_nxt;
        rad_q <= rad_nxt;
        q_q   <= q_nxt;
        if (finish) begin
          result_q <= res_fin;
          sticky_q <= (rem_nxt != '0);
        end
      end
    end
  end

  assign done   = imm_ack || (state_q == S_DONE);
  assign busy   = (state_q == S_BUSY);
  assign result = imm_ack ? ((!special && div0) ? '1 : '0) : result_q;
  assign sticky = imm_ack ? 1'b0 : sticky_q;

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
module tb_fpu_divsqrt_iter;
  localparam int MW = 24;
  localparam int QW = 27;
  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          is_sqrt = 1'b0;
  logic          special = 1'b0;
  logic [MW-1:0] mant_a = '0;
  logic [MW-1:0] mant_b = '0;
  logic          done;
  logic          busy;
  logic [QW-1:0] result;
  logic          sticky;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          sq;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [QW-1:0] res;
    logic          stk;
  } vec_t;

  vec_t vecs [NV];

  fpu_divsqrt_iter #(.MANT_W(MW), .Q_W(QW)) dut (
    .clk(clk), .reset(reset), .start(start), .is_sqrt(is_sqrt),
    .special(special), .mant_a(mant_a), .mant_b(mant_b),
    .done(done), .busy(busy), .result(result), .sticky(sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start an operation at a negedge (cycle 0) and hold start until done.
  // lat is the cycle number where done is first seen, -1 on timeout.
  task automatic run_op(input logic sq, input logic [MW-1:0] a, input logic [MW-1:0] b,
                        output int lat, output logic [QW-1:0] res, output logic stk,
                        output logic hs_bad);
    @(negedge clk);
    is_sqrt = sq; mant_a = a; mant_b = b; special = 1'b0; start = 1'b1;
    #1 hs_bad = busy | done;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
      if (!busy) hs_bad = 1'b1;
    end
    res = result; stk = sticky;
    if (busy) hs_bad = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    if (done || busy) hs_bad = 1'b1;
  endtask

  task automatic chk_lat(input string name, input int lat, input logic stk);
`ifdef FPU_DIVSQRT_EARLY_EXIT_EN
    if (stk) chk(name, 64'(lat), 64'd28);
    else     chk(name, {63'd0, (lat >= 2 && lat <= 28)}, 64'd1);
`else
    chk(name, 64'(lat), 64'd28);
`endif
  endtask

  initial begin
    int            lat;
    logic [QW-1:0] res;
    logic          stk;
    logic          hs_bad;
    logic          seen;

    vecs[0] = '{1'b0, 24'h800000, 24'h800000, 27'h4000000, 1'b0};
    vecs[1] = '{1'b0, 24'h800000, 24'hC00000, 27'h2AAAAAA, 1'b1};
    vecs[2] = '{1'b0, 24'hC00000, 24'h800000, 27'h6000000, 1'b0};
    vecs[3] = '{1'b1, 24'h400000, 24'h000000, 27'h4000000, 1'b0};
    vecs[4] = '{1'b1, 24'h800000, 24'h000000, 27'h5A82799, 1'b1};
    vecs[5] = '{1'b0, 24'hFFFFFF, 24'h800000, 27'h7FFFFF8, 1'b0};
    vecs[6] = '{1'b0, 24'h800000, 24'hFFFFFF, 27'h2000002, 1'b1};
    vecs[7] = '{1'b1, 24'h900000, 24'h800000, 27'h6000000, 1'b0};

    #1 chk("reset_outputs", {60'd0, done, busy, sticky, |result}, 64'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].sq, vecs[i].a, vecs[i].b, lat, res, stk, hs_bad);
      chk($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
      chk($sformatf("vec%0d_sticky", i), 64'(stk), 64'(vecs[i].stk));
      chk_lat($sformatf("vec%0d_latency", i), lat, vecs[i].stk);
      chk($sformatf("vec%0d_handshake", i), 64'(hs_bad), 64'd0);
    end

`ifdef FPU_DIVSQRT_EARLY_EXIT_EN
    run_op(1'b0, 24'h800000, 24'h800000, lat, res, stk, hs_bad);
    chk("early_one_by_one_fast", {63'd0, (lat >= 2 && lat <= 3)}, 64'd1);
    chk("early_one_by_one_res", 64'(res), 64'h4000000);
`endif

    // special operand: same-cycle acknowledge, never busy
    @(negedge clk);
    special = 1'b1; is_sqrt = 1'b0; mant_a = 24'h800000; mant_b = 24'h800000; start = 1'b1;
    #1 chk("special_ack", {61'd0, done, busy, sticky}, 64'b100);
    chk("special_result", 64'(result), 64'd0);
    @(posedge clk); #1 chk("special_stays_idle", {62'd0, done, busy}, 64'b10);
    @(negedge clk); start = 1'b0; special = 1'b0;
    #1 chk("special_release", 64'(done), 64'd0);

    // divide by zero
    @(negedge clk);
    mant_b = 24'h000000; start = 1'b1;
    #1 chk("div0_ack", {62'd0, done, busy}, 64'b10);
    chk("div0_result", 64'(result), 64'h7FFFFFF);
    @(posedge clk); #1 chk("div0_no_busy", 64'(busy), 64'd0);
    @(negedge clk); special = 1'b1;
    #1 chk("special_over_div0", 64'(result), 64'd0);
    @(negedge clk); start = 1'b0; special = 1'b0;

    // abort after 5 busy cycles: done never rises, result untouched
    @(negedge clk);
    mant_a = 24'h800000; mant_b = 24'hC00000; start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1 chk("abort_idle", {62'd0, done, busy}, 64'd0);
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1 if (done) seen = 1'b1; end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_result_kept", 64'(result), 64'(vecs[NV-1].res));

    run_op(1'b0, 24'h800000, 24'h800000, lat, res, stk, hs_bad);
    chk("restart_result", 64'(res), 64'h4000000);
    chk_lat("restart_latency", lat, 1'b0);

    // start drops in the final iteration cycle: back to IDLE, not DONE
    @(negedge clk);
    is_sqrt = 1'b0; mant_a = 24'h800000; mant_b = 24'hC00000; start = 1'b1;
    repeat (27) @(posedge clk);
    #1 chk("last_cycle_busy", {62'd0, done, busy}, 64'b01);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1 chk("last_cycle_abort", {62'd0, done, busy}, 64'd0);
    chk("last_cycle_result_kept", 64'(result), 64'h4000000);

    // reset in the middle of an operation
    @(negedge clk);
    mant_a = 24'hC00000; mant_b = 24'h800000; start = 1'b1;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("reset_mid_busy", {60'd0, done, busy, sticky, |result}, 64'd0);
    start = 1'b0;
    @(negedge clk); reset = 1'b1;

    run_op(1'b1, 24'h800000, 24'h000000, lat, res, stk, hs_bad);
    chk("post_reset_result", 64'(res), 64'h5A82799);
    chk("post_reset_sticky", 64'(stk), 64'd1);
    chk("post_reset_handshake", 64'(hs_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
